mul_group_acc: RTL
==================

# mul_group_acc

Downstream consumer of the ×1/×3/×7/×8 multiplier-select stage. It frames that stage's 11-bit product stream into groups of four beats using the stage's grant pulse. It checks each beat against the group's base value and accumulates the four products into a 13-bit sum (base×19). Completed sums go into a small FIFO toward a back-pressured consumer; the multiplier stage cannot be stalled, so groups that arrive while the FIFO is full are dropped and counted.

## Interface
- FIFO_DEPTH, 2: result FIFO entries; power of two, ≥2.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- grant_in  in  1  high on the first (×1) beat of a group.
- prod_in  in  11  product beat, one per cycle: ×1, ×3, ×7, ×8 of the base.
- sum_out  out  13  FIFO head: sum of the four beats.
- base_out  out  8  FIFO head: base value (beat 0) of that group.
- sum_valid  out  1  FIFO non-empty.
- sum_ready  in  1  consumer pops the head when sum_valid && sum_ready.
- err  out  1  one-cycle pulse on a framing or value error.
- drop_cnt  out  8  saturating count of good groups dropped on FIFO full.

## Operation
- FSM states: IDLE, B1, B2, B3. The state names the beat index expected next.
- IDLE: ignore prod_in until grant_in=1.
  - On grant_in: if prod_in[10:8]≠0, pulse err and stay in IDLE.
  - Otherwise latch base=prod_in[7:0], set acc=prod_in, and go to B1.
- B1/B2/B3: expected beat value is base×3, base×7 and base×8 respectively (11-bit compare).
  - Match: acc += prod_in, then advance. B3 goes to IDLE and writes {acc+prod_in, base} into the FIFO.
  - Mismatch: pulse err, discard the group, go to IDLE.
- grant_in=1 while in B1–B3 (early restart):
  - Pulse err and discard the current group.
  - Treat the beat as a new beat 0 with the IDLE rules: go to B1 if prod_in[10:8]=0, otherwise to IDLE.
- Width rules:
  - acc is 13 bits. Maximum is 255×19=4845, so no overflow is possible.
  - base×8 is computed at 11 bits, maximum 2040.
- FIFO write on completion:
  - Not full, or full with a pop in the same cycle: write accepted.
  - Full with no pop: group dropped, err not pulsed, drop_cnt increments and saturates at 255.
- FIFO read:
  - sum_out/base_out show the head whenever sum_valid=1.
  - When sum_valid=0, sum_out/base_out hold their last value.
- Simultaneous write and pop on an empty FIFO is impossible, because sum_valid=0 blocks the pop.

## Timing
- Reset values: sum_out=0, base_out=0, sum_valid=0, err=0, drop_cnt=0. FSM=IDLE, FIFO empty.
- Reset is asynchronous and takes effect immediately, including mid-group and mid-FIFO contents. Any partial group is lost.
- Beats are sampled on consecutive rising edges E0 (grant) to E3.
- Latency: a result is written at E3; sum_valid=1 after E3 if the FIFO was empty. Total latency is 1 cycle after the last beat.
- err is registered and goes high for exactly one cycle after the edge that detected the error.
- Back-to-back groups need no gap: grant_in may be high the cycle after B3's beat. The upstream issues a grant every 4 cycles.
- Throughput is one group per 4 cycles. With sum_ready held high, the FIFO never holds more than 1 entry.

## Test plan
- Base 10: beats 10,30,70,80 with grant on the first → one cycle later sum_valid=1, sum_out=190, base_out=10, err never set.
- Base 255 then base 0, back-to-back → sums 4845 then 0, in order. Check at the 13-bit boundary.
- Base 20 with the ×7 beat corrupted to 141 → err pulses one cycle after that beat, no FIFO write. The next group (base 3) gives sum_out=57.
- grant_in reasserted at beat 2 with value 5, followed by 15,35,40 → one err pulse, then sum_out=95, base_out=5.
- sum_ready=0 and FIFO_DEPTH=2, with three groups of bases 1, 2, 3 → FIFO holds 19 and 38, drop_cnt=1. Releasing ready pops 19 then 38.
- Assert rst during B2 with a full FIFO → all outputs reset asynchronously. After release, a group with base 7 produces sum_out=133.

Source files
------------

// File: rtl/mul_group_acc.sv
// Frames the x1/x3/x7/x8 product stream into 4-beat groups, checks each beat
// against the group base and queues base*19 sums in a small drop-on-full FIFO.
module mul_group_acc #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        grant_in,
    input  logic [10:0] prod_in,
    output logic [12:0] sum_out,
    output logic [7:0]  base_out,
    output logic        sum_valid,
    input  logic        sum_ready,
    output logic        err,
    output logic [7:0]  drop_cnt
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, B1, B2, B3} state_t;

    typedef struct packed {
        logic [12:0] sum;
        logic [7:0]  base;
    } entry_t;

    state_t      state, state_n;
    logic [7:0]  base;
    logic [12:0] acc;
    logic [10:0] base_w, exp_val;
    logic        err_n, load, acc_add, done;

    entry_t      mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, last_ptr, head_ptr;
    logic [AW:0]   count;
    logic        full, pop, wr_en, drop_en;

    assign base_w = {3'b000, base};

    always_comb begin
        exp_val = base_w;
        case (state)
            B1:      exp_val = base_w + (base_w << 1);
            B2:      exp_val = (base_w << 3) - base_w;
            B3:      exp_val = base_w << 3;
            default: exp_val = base_w;
        endcase
    end

    // A grant always starts a fresh group, aborting any group in flight.
    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        load    = 1'b0;
        acc_add = 1'b0;
        done    = 1'b0;
        if (grant_in) begin
            if (state != IDLE) err_n = 1'b1;
            if (prod_in[10:8] != 3'b000) begin
                err_n   = 1'b1;
                state_n = IDLE;
            end else begin
                load    = 1'b1;
                state_n = B1;
            end
        end else if (state != IDLE) begin
            if (prod_in == exp_val) begin
                acc_add = 1'b1;
                case (state)
                    B1:      state_n = B2;
                    B2:      state_n = B3;
                    default: begin
                        state_n = IDLE;
                        done    = 1'b1;
                    end
                endcase
            end else begin
                err_n   = 1'b1;
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            base  <= '0;
            acc   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            err   <= err_n;
            if (load) begin
                base <= prod_in[7:0];
                acc  <= {2'b00, prod_in};
            end else if (acc_add) begin
                acc <= acc + {2'b00, prod_in};
            end
        end
    end

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign sum_valid = (count != '0);
    assign pop     = sum_valid && sum_ready;
    assign wr_en   = done && (!full || pop);
    assign drop_en = done && full && !pop;

    // When empty, the slot just behind rd_ptr still holds the last popped entry.
    assign last_ptr = rd_ptr - AW'(1);
    assign head_ptr = sum_valid ? rd_ptr : last_ptr;
    assign sum_out  = mem[head_ptr].sum;
    assign base_out = mem[head_ptr].base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= '{sum: acc + {2'b00, prod_in}, base: base};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop_en && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule
